mips_trace_buffer: RTL and testbench
====================================

Name: mips_trace_buffer

Overview:
- Parametrised commit-trace capture unit for the MIPS core.
- Records per-cycle architectural events (pc, instr, register write-back) into an on-chip circular buffer, starting on an arm command or a PC trigger.
- Captured entries are drained through a valid/ready readout port.
- Replaces hierarchical register-file probing in benches and provides on-chip debug visibility.

Parameters:
- DEPTH, 16, number of trace entries; power of two, >= 2.
- PC_W, 32, width of pc and trig_pc.
- DATA_W, 32, width of write-back data.
- WRAP, 0, 0 = stop capturing when full; 1 = overwrite oldest entry when full.
- FILTER_WE, 1, 1 = record only cycles with reg_write=1; 0 = record every cycle in CAPTURE.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- arm  in  1  pulse: clear buffer and enter ARMED.
- stop  in  1  pulse: end capture.
- trig_en  in  1  1 = wait for pc==trig_pc; 0 = trigger immediately.
- trig_pc  in  PC_W  trigger address.
- pc  in  PC_W  current-cycle pc.
- instr  in  32  current-cycle instruction.
- reg_write  in  1  current-cycle register write enable.
- wa  in  5  write-back register index.
- wd  in  DATA_W  write-back data.
- rd_valid  out  1  buffer non-empty.
- rd_ready  in  1  consumer accepts head entry.
- rd_pc  out  PC_W  head entry pc.
- rd_instr  out  32  head entry instr.
- rd_we  out  1  head entry reg_write.
- rd_wa  out  5  head entry wa.
- rd_wd  out  DATA_W  head entry wd.
- count  out  $clog2(DEPTH)+1  entries held, 0..DEPTH.
- state  out  2  0=IDLE, 1=ARMED, 2=CAPTURE, 3=DONE.
- overflow  out  1  sticky: an entry was lost (WRAP=0, write while full) or overwritten (WRAP=1).

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE, count=0, pointers=0, overflow=0, rd_valid=0. rd_* outputs read as 0 while empty.
- Record qualifier q = (state==CAPTURE or trigger firing this cycle) and (FILTER_WE==0 or reg_write==1) and stop==0 and arm==0.
- FSM, in priority order each edge:
  - arm=1 in any state -> ARMED; count, pointers and overflow cleared; nothing recorded.
  - stop=1: ARMED -> IDLE; CAPTURE -> DONE; IDLE and DONE unchanged.
  - ARMED: if trig_en=0, or pc==trig_pc, -> CAPTURE. The trigger cycle itself is recorded if q holds.
  - CAPTURE with WRAP=0 and count==DEPTH after this edge -> DONE.
  - DONE and IDLE hold until arm.
- Push: on q, entry {pc, instr, reg_write, wa, wd} written at the write pointer, latency 1 (visible on rd_* the next cycle if it becomes head).
- Pop: rd_valid & rd_ready at the edge removes the head entry. Pops are permitted in every state, including during capture. Pop while empty is ignored.
- rd_* are show-ahead: they present the oldest entry combinationally whenever rd_valid=1, and stay stable until popped.
- Simultaneous push and pop with count between 1 and DEPTH-1: count unchanged.
- Full (count==DEPTH) with push:
  - With pop the same cycle: both accepted, count stays DEPTH, no overflow.
  - WRAP=0, no pop: state goes to DONE on the edge count reaches DEPTH, so pushes cannot normally occur. A qualifying event arriving while full sets overflow=1 and the entry is dropped.
  - WRAP=1, no pop: oldest entry overwritten, read pointer advances, count stays DEPTH, overflow=1.
- Pointers wrap modulo DEPTH. count is exact, with no aliasing at full/empty.
- Reset mid-capture: all state is lost and buffer contents are invalid. Reset dominates arm and stop.

Test Plan:
- DEPTH=4, WRAP=0, FILTER_WE=1, trig_en=0. Sequence: arm; then 3 cycles reg_write=1 (wa=1,2,3; wd=0x11,0x22,0x33) and 1 cycle reg_write=0. Required: state=CAPTURE, count=3, rd_wa=1, rd_wd=0x11. Then rd_ready=1 for 3 cycles: entries popped in order 1,2,3; rd_valid=0 after.
- trig_en=1, trig_pc=0x0000000C; pc steps 0,4,8,0xC,0x10 with reg_write=1 every cycle. Required: ARMED until pc=0xC; first recorded rd_pc=0xC; count=2 after pc=0x10.
- WRAP=0, DEPTH=4: 6 qualifying cycles, no pops. Required: state=DONE after the 4th; count=4; rd_pc equals the 1st event's pc; overflow=0. Then arm: count=0, state=ARMED.
- WRAP=1, DEPTH=4: 6 qualifying cycles, wd=1..6. Required: count=4; overflow=1; drain yields wd 3,4,5,6.
- Full buffer, WRAP=1: push with simultaneous pop. Required: count=4, overflow stays 0, popped entry is the old head. Also: pop while empty -> count stays 0.
- Mid-capture with count=2: rst_n=0 for 1 cycle. Required: state=IDLE, count=0, rd_valid=0, overflow=0. Same cycle arm=1 and stop=1 in CAPTURE: state=ARMED (arm wins), count=0.

Source files
------------

// File: rtl/mips_trace_buffer_if.sv
// Trace capture bus: commit-event source, control inputs and the readout/status side.
interface mips_trace_buffer_if #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic              arm;
  logic              stop;
  logic              trig_en;
  logic [PC_W-1:0]   trig_pc;
  logic [PC_W-1:0]   pc;
  logic [31:0]       instr;
  logic              reg_write;
  logic [4:0]        wa;
  logic [DATA_W-1:0] wd;

  logic              rd_valid;
  logic              rd_ready;
  logic [PC_W-1:0]   rd_pc;
  logic [31:0]       rd_instr;
  logic              rd_we;
  logic [4:0]        rd_wa;
  logic [DATA_W-1:0] rd_wd;
  logic [CW-1:0]     count;
  logic [1:0]        state;
  logic              overflow;

  modport master (
    output arm, stop, trig_en, trig_pc, pc, instr, reg_write, wa, wd, rd_ready,
    input  rd_valid, rd_pc, rd_instr, rd_we, rd_wa, rd_wd, count, state, overflow
  );

  modport slave (
    input  arm, stop, trig_en, trig_pc, pc, instr, reg_write, wa, wd, rd_ready,
    output rd_valid, rd_pc, rd_instr, rd_we, rd_wa, rd_wd, count, state, overflow
  );
endinterface

// File: rtl/mips_trace_buffer.sv
// Commit-trace capture: records pc/instr/write-back events into a circular buffer
// after arm or a pc trigger, drained through a show-ahead valid/ready port.
module mips_trace_buffer #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned PC_W      = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned WRAP      = 0,
  parameter int unsigned FILTER_WE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  mips_trace_buffer_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [31:0]       instr;
    logic              we;
    logic [4:0]        wa;
    logic [DATA_W-1:0] wd;
  } entry_t;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  entry_t        mem_q [DEPTH];

  logic   full_c, pop_c, fire_c, rec_c, wr_en_c, grow_c, valid_c;
  entry_t wr_entry_c, head_c;

  assign full_c     = (count_q == CW'(DEPTH));
  assign pop_c      = (count_q != '0) && bus.rd_ready;
  assign fire_c     = (state_q == ARMED) && !bus.arm && !bus.stop &&
                      (!bus.trig_en || (bus.pc == bus.trig_pc));
  assign rec_c      = ((state_q == CAPTURE) || fire_c) &&
                      ((FILTER_WE == 0) || bus.reg_write) && !bus.stop && !bus.arm;
  assign wr_entry_c = {bus.pc, bus.instr, bus.reg_write, bus.wa, bus.wd};

  // Next-state: arm dominates, then stop, then trigger and fill-to-done.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    wr_en_c    = 1'b0;
    grow_c     = 1'b0;

    if (bus.arm) begin
      state_d    = ARMED;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (rec_c) begin
        if (!full_c || pop_c) begin
          wr_en_c  = 1'b1;
          grow_c   = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
        end else if (WRAP != 0) begin
          // Full without a pop: overwrite the oldest entry and slide the head.
          wr_en_c    = 1'b1;
          wr_ptr_d   = wr_ptr_q + AW'(1);
          rd_ptr_d   = rd_ptr_q + AW'(1);
          overflow_d = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end
      count_d = count_q + CW'(grow_c) - CW'(pop_c);

      unique case (state_q)
        ARMED: begin
          if (bus.stop) begin
            state_d = IDLE;
          end else if (fire_c) begin
            state_d = CAPTURE;
          end
        end
        CAPTURE: begin
          if (bus.stop) begin
            state_d = DONE;
          end
        end
        default: ;
      endcase

      if ((state_d == CAPTURE) && (WRAP == 0) && (count_d == CW'(DEPTH))) begin
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en_c) begin
      mem_q[wr_ptr_q] <= wr_entry_c;
    end
  end

  assign valid_c = (count_q != '0);
  assign head_c  = mem_q[rd_ptr_q];

  assign bus.rd_valid = valid_c;
  assign bus.rd_pc    = valid_c ? head_c.pc    : '0;
  assign bus.rd_instr = valid_c ? head_c.instr : '0;
  assign bus.rd_we    = valid_c ? head_c.we    : 1'b0;
  assign bus.rd_wa    = valid_c ? head_c.wa    : '0;
  assign bus.rd_wd    = valid_c ? head_c.wd    : '0;
  assign bus.count    = count_q;
  assign bus.state    = state_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_mips_trace_buffer.sv
// Bench for mips_trace_buffer: three configurations against a queue-based model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mips_trace_buffer;
  localparam int unsigned DEPTH = 4;
  localparam int NI = 3;
  localparam int ST_IDLE = 0, ST_ARMED = 1, ST_CAP = 2, ST_DONE = 3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arm = 1'b0, stop = 1'b0, trig_en = 1'b0, reg_write = 1'b0, rd_ready = 1'b0;
  logic [31:0] trig_pc = '0, pc = '0, instr = '0, wd = '0;
  logic [4:0]  wa = '0;

  logic        o_valid [NI];
  logic [31:0] o_pc    [NI];
  logic [31:0] o_instr [NI];
  logic        o_we    [NI];
  logic [4:0]  o_wa    [NI];
  logic [31:0] o_wd    [NI];
  logic [2:0]  o_cnt   [NI];
  logic [1:0]  o_st    [NI];
  logic        o_ovf   [NI];

  int   checks = 0;
  int   errors = 0;
  bit   chk_on = 1'b0;
  ent_t mq [NI][$];
  int   ms [NI];
  bit   movf [NI];

  always #5 clk = ~clk;

  // Instance 0: WRAP=0 FILTER_WE=1; 1: WRAP=1 FILTER_WE=1; 2: WRAP=1 FILTER_WE=0.
  for (genvar g = 0; g < NI; g++) begin : g_dut
    mips_trace_buffer_if #(.DEPTH(DEPTH), .PC_W(32), .DATA_W(32)) bus ();
    assign bus.arm       = arm;
    assign bus.stop      = stop;
    assign bus.trig_en   = trig_en;
    assign bus.trig_pc   = trig_pc;
    assign bus.pc        = pc;
    assign bus.instr     = instr;
    assign bus.reg_write = reg_write;
    assign bus.wa        = wa;
    assign bus.wd        = wd;
    assign bus.rd_ready  = rd_ready;
    assign o_valid[g] = bus.rd_valid;
    assign o_pc[g]    = bus.rd_pc;
    assign o_instr[g] = bus.rd_instr;
    assign o_we[g]    = bus.rd_we;
    assign o_wa[g]    = bus.rd_wa;
    assign o_wd[g]    = bus.rd_wd;
    assign o_cnt[g]   = bus.count;
    assign o_st[g]    = bus.state;
    assign o_ovf[g]   = bus.overflow;
    mips_trace_buffer #(
      .DEPTH(DEPTH), .PC_W(32), .DATA_W(32),
      .WRAP((g == 0) ? 0 : 1), .FILTER_WE((g == 2) ? 0 : 1)
    ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
    );
  end

  function automatic bit wrap_of(int k);
    return k != 0;
  endfunction

  function automatic bit filt_of(int k);
    return k != 2;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: one edge of each configuration, expressed with a queue of entries.
  task automatic model_step();
    ent_t e;
    bit   pop, fire, rec;
    e = '{pc: pc, instr: instr, we: reg_write, wa: wa, wd: wd};
    for (int k = 0; k < NI; k++) begin
      if (!rst_n || arm) begin
        mq[k].delete();
        movf[k] = 1'b0;
        ms[k] = rst_n ? ST_ARMED : ST_IDLE;
        continue;
      end
      pop  = (mq[k].size() > 0) && rd_ready;
      fire = (ms[k] == ST_ARMED) && !stop && (!trig_en || (pc == trig_pc));
      rec  = ((ms[k] == ST_CAP) || fire) && (!filt_of(k) || reg_write) && !stop;
      if (pop) void'(mq[k].pop_front());
      if (rec) begin
        if (mq[k].size() < DEPTH) begin
          mq[k].push_back(e);
        end else begin
          movf[k] = 1'b1;
          if (wrap_of(k)) begin
            void'(mq[k].pop_front());
            mq[k].push_back(e);
          end
        end
      end
      if (stop) begin
        if (ms[k] == ST_ARMED) ms[k] = ST_IDLE;
        else if (ms[k] == ST_CAP) ms[k] = ST_DONE;
      end else if (fire) begin
        ms[k] = ST_CAP;
      end
      if ((ms[k] == ST_CAP) && !wrap_of(k) && (mq[k].size() == DEPTH)) ms[k] = ST_DONE;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
    if (!rst_n) chk_on = 1'b1;
  endtask

  task automatic ev(logic [31:0] p, logic rw, logic [4:0] a, logic [31:0] d);
    pc = p; reg_write = rw; wa = a; wd = d; instr = $urandom;
    step();
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  // Every-cycle comparison of all instances against the model.
  always @(negedge clk) begin : cmp
    ent_t h;
    if (chk_on) begin
      for (int k = 0; k < NI; k++) begin
        h = (mq[k].size() > 0) ? mq[k][0] : '0;
        chk($sformatf("valid%0d", k), 32'(o_valid[k]), 32'(mq[k].size() > 0));
        chk($sformatf("count%0d", k), 32'(o_cnt[k]), 32'(mq[k].size()));
        chk($sformatf("state%0d", k), 32'(o_st[k]), 32'(ms[k]));
        chk($sformatf("ovf%0d", k), 32'(o_ovf[k]), 32'(movf[k]));
        chk($sformatf("rd_pc%0d", k), o_pc[k], h.pc);
        chk($sformatf("rd_instr%0d", k), o_instr[k], h.instr);
        chk($sformatf("rd_we%0d", k), 32'(o_we[k]), 32'(h.we));
        chk($sformatf("rd_wa%0d", k), 32'(o_wa[k]), 32'(h.wa));
        chk($sformatf("rd_wd%0d", k), o_wd[k], h.wd);
      end
    end
  end

  initial begin
    int rdp;
    rst_n = 1'b0;
    step();
    step();
    chk("rst_state", 32'(o_st[0]), ST_IDLE);
    chk("rst_count", 32'(o_cnt[0]), 0);
    chk("rst_valid", 32'(o_valid[0]), 0);
    rst_n = 1'b1;

    // Immediate trigger, filtered capture, ordered drain.
    trig_en = 1'b0;
    pulse_arm();
    ev(32'h40, 1'b1, 5'd1, 32'h11);
    ev(32'h44, 1'b1, 5'd2, 32'h22);
    ev(32'h48, 1'b1, 5'd3, 32'h33);
    ev(32'h4c, 1'b0, 5'd4, 32'h44);
    chk("tp1_state", 32'(o_st[0]), ST_CAP);
    chk("tp1_count", 32'(o_cnt[0]), 3);
    chk("tp1_wa", 32'(o_wa[0]), 1);
    chk("tp1_wd", o_wd[0], 32'h11);
    reg_write = 1'b0;
    rd_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      chk("tp1_pop_wa", 32'(o_wa[0]), 32'(i));
      step();
    end
    rd_ready = 1'b0;
    chk("tp1_empty", 32'(o_valid[0]), 0);

    // PC trigger.
    trig_en = 1'b1;
    trig_pc = 32'hC;
    pulse_arm();
    ev(32'h0, 1'b1, 5'd1, 32'h1);
    chk("tp2_armed0", 32'(o_st[0]), ST_ARMED);
    ev(32'h4, 1'b1, 5'd2, 32'h2);
    ev(32'h8, 1'b1, 5'd3, 32'h3);
    chk("tp2_armed8", 32'(o_st[0]), ST_ARMED);
    ev(32'hC, 1'b1, 5'd4, 32'h4);
    chk("tp2_cap", 32'(o_st[0]), ST_CAP);
    chk("tp2_pc", o_pc[0], 32'hC);
    ev(32'h10, 1'b1, 5'd5, 32'h5);
    chk("tp2_count", 32'(o_cnt[0]), 2);

    // Fill past DEPTH: stop-when-full versus overwrite.
    trig_en = 1'b0;
    pulse_arm();
    for (int i = 0; i < 6; i++) begin
      ev(32'h100 + 32'(4 * i), 1'b1, 5'(i + 1), 32'(i + 1));
      if (i == 3) begin
        chk("tp3_done", 32'(o_st[0]), ST_DONE);
        chk("tp3_full", 32'(o_cnt[0]), 4);
      end
    end
    chk("tp3_count", 32'(o_cnt[0]), 4);
    chk("tp3_head_pc", o_pc[0], 32'h100);
    chk("tp3_ovf", 32'(o_ovf[0]), 0);
    chk("tp4_count", 32'(o_cnt[1]), 4);
    chk("tp4_ovf", 32'(o_ovf[1]), 1);
    reg_write = 1'b0;
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("tp4_drain_wd", o_wd[1], 32'(3 + i));
      chk("tp3_drain_wd", o_wd[0], 32'(1 + i));
      step();
    end
    rd_ready = 1'b0;
    pulse_arm();
    chk("tp3_arm_count", 32'(o_cnt[0]), 0);
    chk("tp3_arm_state", 32'(o_st[0]), ST_ARMED);

    // Full with simultaneous push and pop, then pop while empty.
    for (int i = 0; i < 4; i++) ev(32'h200 + 32'(4 * i), 1'b1, 5'(i), 32'hA0 + 32'(i));
    chk("tp5_head_old", o_wd[1], 32'hA0);
    rd_ready = 1'b1;
    ev(32'h210, 1'b1, 5'd5, 32'hA4);
    rd_ready = 1'b0;
    chk("tp5_count", 32'(o_cnt[1]), 4);
    chk("tp5_ovf", 32'(o_ovf[1]), 0);
    chk("tp5_head_new", o_wd[1], 32'hA1);
    pulse_arm();
    reg_write = 1'b0;
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    chk("tp5_empty_pop0", 32'(o_cnt[0]), 0);
    chk("tp5_empty_pop1", 32'(o_cnt[1]), 0);

    // Reset mid-capture, then arm and stop together.
    pulse_arm();
    ev(32'h300, 1'b1, 5'd1, 32'h1);
    ev(32'h304, 1'b1, 5'd2, 32'h2);
    chk("tp6_pre_count", 32'(o_cnt[0]), 2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("tp6_state", 32'(o_st[0]), ST_IDLE);
    chk("tp6_count", 32'(o_cnt[0]), 0);
    chk("tp6_valid", 32'(o_valid[0]), 0);
    chk("tp6_ovf", 32'(o_ovf[1]), 0);
    pulse_arm();
    ev(32'h308, 1'b1, 5'd3, 32'h3);
    chk("tp6_cap", 32'(o_st[0]), ST_CAP);
    arm = 1'b1;
    stop = 1'b1;
    step();
    arm = 1'b0;
    stop = 1'b0;
    chk("tp6_arm_wins", 32'(o_st[0]), ST_ARMED);
    chk("tp6_arm_count", 32'(o_cnt[0]), 0);

    // Randomized traffic with phases of slow and fast draining.
    for (int n = 0; n < 3000; n++) begin
      rdp = (n / 200) % 3;
      arm   = ($urandom_range(0, 39) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      rst_n = ($urandom_range(0, 399) != 0);
      if (arm) begin
        trig_en = 1'($urandom_range(0, 1));
        trig_pc = 32'(4 * $urandom_range(0, 15));
      end
      pc        = 32'(4 * $urandom_range(0, 15));
      instr     = $urandom;
      reg_write = ($urandom_range(0, 9) < 7);
      wa        = 5'($urandom);
      wd        = $urandom;
      rd_ready  = (rdp == 0) ? 1'b0 : (rdp == 1) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
      step();
    end
    arm = 1'b0;
    stop = 1'b0;
    rst_n = 1'b1;
    rd_ready = 1'b0;
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
